fractal_sync_rf_requester: RTL and testbench
============================================

FRACTAL_SYNC_RF_REQUESTER -- requirements
Module: fractal_sync_rf_requester

Interface
REQ-001 SHALL have parameter LEVEL_WIDTH, default 1, width of the synchronization level field.
REQ-002 SHALL have parameter ID_WIDTH, default 1, width of the barrier ID field.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, request buffer depth; must be a power of 2 and at least 2 (elaboration-time fatal otherwise).
REQ-004 SHALL use one clock; reset is asynchronous and active-low, ports named clk_i and rst_ni.
REQ-005 clk_i  input  1  block clock.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 req_valid_i  input  1  request valid.
REQ-008 req_ready_o  output  1  request buffer can accept a request.
REQ-009 req_level_i  input  LEVEL_WIDTH  level of the request.
REQ-010 req_id_i  input  ID_WIDTH  barrier ID of the request.
REQ-011 rf_level_o  output  LEVEL_WIDTH  level presented to the remote RF port.
REQ-012 rf_id_o  output  ID_WIDTH  ID presented to the remote RF port.
REQ-013 rf_check_o  output  1  one-cycle check strobe to the RF port.
REQ-014 rf_present_i / rf_sig_err_i / rf_bypass_i / rf_ignore_i  input  1 each  RF port results, combinationally valid in the cycle rf_check_o=1.
REQ-015 rsp_valid_o  output  1  response valid.
REQ-016 rsp_ready_i  input  1  response accepted.
REQ-017 rsp_level_o / rsp_id_o  output  LEVEL_WIDTH / ID_WIDTH  level and ID echoed from the checked request.
REQ-018 rsp_kind_o  output  2  response kind: WAIT=0, DONE=1, DROP=2, ERR=3.
REQ-019 err_cnt_o  output  16  saturating count of ERR responses.

Function
REQ-020 A request SHALL be pushed into the FIFO when req_valid_i and req_ready_o are both 1; req_ready_o = not full.
REQ-021 The FSM SHALL have states IDLE, ISSUE and RESP, and SHALL leave reset in IDLE.
REQ-022 In IDLE with the FIFO non-empty, the FSM SHALL move to ISSUE on the next cycle.
REQ-023 In ISSUE the block SHALL, for exactly one cycle, drive rf_check_o=1 and rf_level_o/rf_id_o from the FIFO head.
REQ-024 In the same ISSUE cycle it SHALL register the response, pop the FIFO head, and go to RESP.
REQ-025 Response kind priority SHALL be: rf_sig_err_i -> ERR; else rf_ignore_i -> DROP; else rf_bypass_i or rf_present_i -> DONE; else WAIT.
REQ-026 In RESP, rsp_valid_o SHALL be 1 and all rsp_* outputs SHALL be held stable until rsp_ready_i=1.
REQ-027 On the RESP handshake the FSM SHALL go to ISSUE if the FIFO is non-empty that cycle, otherwise to IDLE.
REQ-028 Minimum spacing SHALL be one check every 2 cycles; latency from push into an empty FIFO with idle FSM to rsp_valid_o is 2 cycles.
REQ-029 Outside ISSUE, rf_check_o SHALL be 0 and rf_level_o/rf_id_o SHALL be 0.
REQ-030 A simultaneous push and pop SHALL be legal when full; req_ready_o reflects registered fullness only (no pass-through).
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH, using an extra MSB for the full/empty distinction.
REQ-032 err_cnt_o SHALL increment on each accepted ERR response handshake and saturate at 16'hFFFF.

Reset
REQ-033 Reset SHALL set: FSM=IDLE, FIFO empty, req_ready_o=1, rf_check_o=0, rsp_valid_o=0, rsp_kind_o=WAIT, rsp_level_o=0, rsp_id_o=0, err_cnt_o=0.
REQ-034 Reset asserted mid-operation SHALL discard buffered requests and any pending response, with no rf_check_o pulse after deassertion until a new push.

Structure
REQ-035 The rsp_kind_e typedef (WAIT, DONE, DROP, ERR) SHALL be added to fractal_sync_pkg.
REQ-036 The FIFO SHALL be a sub-module, fractal_sync_req_fifo, parameterized by data width and depth.

Verification
REQ-037 Single request: push level=1, id=0 with RF present=0 -> rf_check_o high exactly 1 cycle at t+1; rsp WAIT at t+2, level=1, id=0.
REQ-038 Pair completion: two requests with id=1, RF present=0 then 1 -> responses WAIT then DONE, in order.
REQ-039 Error: rf_sig_err_i=1 together with present=1 -> kind ERR; err_cnt_o becomes 1 after the handshake; force 65536 errors -> err_cnt_o stays 16'hFFFF.
REQ-040 Backpressure: hold rsp_ready_i=0 and push until full (2 requests) -> req_ready_o=0, rsp_* held stable; release -> FIFO drains in order, one check every 2 cycles.
REQ-041 Priority: ignore=1 with bypass=1 -> DROP; bypass=1 alone -> DONE.
REQ-042 Reset mid-RESP with 1 request buffered -> rsp_valid_o=0, req_ready_o=1; no rf_check_o pulse for 10 cycles after reset release.

Source files
------------

// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal synchronization request path: response kinds,
// requester FSM states and the response classification helper.
package fractal_sync_pkg;

   // Response kinds reported back to the requester.
   typedef enum logic [1:0] {
      RSP_WAIT = 2'd0,
      RSP_DONE = 2'd1,
      RSP_DROP = 2'd2,
      RSP_ERR  = 2'd3
   } rsp_kind_e;

   // Requester control states.
   typedef enum logic [1:0] {
      REQ_IDLE  = 2'd0,
      REQ_ISSUE = 2'd1,
      REQ_RESP  = 2'd2
   } req_state_e;

   localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

   // Classify the RF lookup result. A signalling error dominates everything,
   // an ignore dominates completion, and bypass counts as completion.
   function automatic rsp_kind_e resolve_kind(
      input logic sig_err,
      input logic ignore,
      input logic bypass,
      input logic present
   );
      rsp_kind_e kind;
      if (sig_err) begin
         kind = RSP_ERR;
      end else if (ignore) begin
         kind = RSP_DROP;
      end else if (bypass || present) begin
         kind = RSP_DONE;
      end else begin
         kind = RSP_WAIT;
      end
      return kind;
   endfunction

endpackage

// File: rtl/fractal_sync_req_fifo.sv
// Request buffer for the RF requester. Power-of-two depth; pointers carry an
// extra wrap bit so full and empty are distinguishable without a counter.
module fractal_sync_req_fifo #(
   parameter int unsigned DATA_WIDTH = 2,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  full_o,
   output logic                  empty_o
);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $fatal(1, "fractal_sync_req_fifo: DEPTH must be a power of 2 and at least 2");
   end

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]           wptr_q, wptr_d;
   logic [AW:0]           rptr_q, rptr_d;
   logic                  full_s, empty_s;
   logic                  push_en_s, pop_en_s;

   assign empty_s   = (wptr_q == rptr_q);
   assign full_s    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign push_en_s = push_i && (!full_s || pop_i);
   assign pop_en_s  = pop_i && !empty_s;

   assign data_o  = mem_q[rptr_q[AW-1:0]];
   assign full_o  = full_s;
   assign empty_o = empty_s;

   // Next pointer values; both wrap naturally through the extra MSB.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_en_s) begin
         wptr_d = wptr_q + PTR_ONE;
      end else begin
         wptr_d = wptr_q;
      end
      if (pop_en_s) begin
         rptr_d = rptr_q + PTR_ONE;
      end else begin
         rptr_d = rptr_q;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= {(AW + 1){1'b0}};
         rptr_q <= {(AW + 1){1'b0}};
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage: the tail slot is written on an accepted push.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (push_en_s) begin
         mem_q[wptr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/fractal_sync_rf_requester.sv
// Buffers synchronization requests, checks each one against the remote RF
// with a single-cycle strobe, and returns a classified response.
module fractal_sync_rf_requester
   import fractal_sync_pkg::*;
#(
   parameter int unsigned LEVEL_WIDTH = 1,
   parameter int unsigned ID_WIDTH    = 1,
   parameter int unsigned FIFO_DEPTH  = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [LEVEL_WIDTH-1:0] req_level_i,
   input  logic [ID_WIDTH-1:0]    req_id_i,
   output logic [LEVEL_WIDTH-1:0] rf_level_o,
   output logic [ID_WIDTH-1:0]    rf_id_o,
   output logic                   rf_check_o,
   input  logic                   rf_present_i,
   input  logic                   rf_sig_err_i,
   input  logic                   rf_bypass_i,
   input  logic                   rf_ignore_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [LEVEL_WIDTH-1:0] rsp_level_o,
   output logic [ID_WIDTH-1:0]    rsp_id_o,
   output logic [1:0]             rsp_kind_o,
   output logic [15:0]            err_cnt_o
);

   localparam int unsigned DW = LEVEL_WIDTH + ID_WIDTH;

   req_state_e             state_q, state_d;
   rsp_kind_e              rsp_kind_q, rsp_kind_d;
   logic [LEVEL_WIDTH-1:0] rsp_level_q, rsp_level_d;
   logic [ID_WIDTH-1:0]    rsp_id_q, rsp_id_d;
   logic [15:0]            err_cnt_q, err_cnt_d;

   logic                   fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
   logic [DW-1:0]          fifo_wdata_s, fifo_head_s;
   logic [LEVEL_WIDTH-1:0] head_level_s;
   logic [ID_WIDTH-1:0]    head_id_s;
   logic                   issue_s, rsp_hs_s;

   // Ready depends only on registered fullness, so a pop never lets a push through.
   assign req_ready_o  = !fifo_full_s;
   assign fifo_push_s  = req_valid_i && !fifo_full_s;
   assign fifo_wdata_s = {req_level_i, req_id_i};
   assign head_level_s = fifo_head_s[DW-1:ID_WIDTH];
   assign head_id_s    = fifo_head_s[ID_WIDTH-1:0];

   assign issue_s    = (state_q == REQ_ISSUE);
   assign rsp_hs_s   = (state_q == REQ_RESP) && rsp_ready_i;
   assign fifo_pop_s = issue_s;

   fractal_sync_req_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (FIFO_DEPTH)
   ) i_req_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (fifo_push_s),
      .data_i  (fifo_wdata_s),
      .pop_i   (fifo_pop_s),
      .data_o  (fifo_head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   // Next-state logic: one check per buffered request, then hold the response.
   always_comb begin
      state_d = state_q;
      case (state_q)
         REQ_IDLE: begin
            if (!fifo_empty_s) begin
               state_d = REQ_ISSUE;
            end else begin
               state_d = REQ_IDLE;
            end
         end
         REQ_ISSUE: begin
            state_d = REQ_RESP;
         end
         REQ_RESP: begin
            if (rsp_ready_i) begin
               state_d = fifo_empty_s ? REQ_IDLE : REQ_ISSUE;
            end else begin
               state_d = REQ_RESP;
            end
         end
         default: begin
            state_d = REQ_IDLE;
         end
      endcase
   end

   // Response capture in the check cycle, and saturating error count on handshake.
   always_comb begin
      rsp_kind_d  = rsp_kind_q;
      rsp_level_d = rsp_level_q;
      rsp_id_d    = rsp_id_q;
      err_cnt_d   = err_cnt_q;
      if (issue_s) begin
         rsp_kind_d  = resolve_kind(rf_sig_err_i, rf_ignore_i, rf_bypass_i, rf_present_i);
         rsp_level_d = head_level_s;
         rsp_id_d    = head_id_s;
      end else begin
         rsp_kind_d  = rsp_kind_q;
         rsp_level_d = rsp_level_q;
         rsp_id_d    = rsp_id_q;
      end
      if (rsp_hs_s && (rsp_kind_q == RSP_ERR) && (err_cnt_q != ERR_CNT_MAX)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // State and response registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= REQ_IDLE;
         rsp_kind_q  <= RSP_WAIT;
         rsp_level_q <= {LEVEL_WIDTH{1'b0}};
         rsp_id_q    <= {ID_WIDTH{1'b0}};
         err_cnt_q   <= 16'd0;
      end else begin
         state_q     <= state_d;
         rsp_kind_q  <= rsp_kind_d;
         rsp_level_q <= rsp_level_d;
         rsp_id_q    <= rsp_id_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // The RF port sees the head entry only during the check cycle, zeros otherwise.
   assign rf_check_o  = issue_s;
   assign rf_level_o  = issue_s ? head_level_s : {LEVEL_WIDTH{1'b0}};
   assign rf_id_o     = issue_s ? head_id_s : {ID_WIDTH{1'b0}};

   assign rsp_valid_o = (state_q == REQ_RESP);
   assign rsp_kind_o  = rsp_kind_q;
   assign rsp_level_o = rsp_level_q;
   assign rsp_id_o    = rsp_id_q;
   assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_fractal_sync_rf_requester.sv
// Directed and randomized bench for fractal_sync_rf_requester with a
// queue-based reference model of requests in flight and expected responses.
module tb_fractal_sync_rf_requester;

   localparam int LW    = 2;
   localparam int IW    = 3;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [LW-1:0] lvl;
      logic [IW-1:0] id;
      logic [3:0]    plan;   // {sig_err, ignore, bypass, present}
   } req_t;

   typedef struct packed {
      logic [LW-1:0] lvl;
      logic [IW-1:0] id;
      logic [1:0]    kind;
   } rsp_t;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          req_valid_i, req_ready_o;
   logic [LW-1:0] req_level_i, rf_level_o, rsp_level_o;
   logic [IW-1:0] req_id_i, rf_id_o, rsp_id_o;
   logic          rf_check_o, rf_present_i, rf_sig_err_i, rf_bypass_i, rf_ignore_i;
   logic          rsp_valid_o, rsp_ready_i;
   logic [1:0]    rsp_kind_o;
   logic [15:0]   err_cnt_o;

   int            total = 0;
   int            bad = 0;
   int            cyc_n = 0;
   req_t          req_q[$];
   rsp_t          rsp_q[$];
   logic [1:0]    hs_log[$];
   int            chk_cyc[$];
   logic [15:0]   err_model = 16'd0;
   logic          prev_check = 1'b0;
   logic          last_check = 1'b0;
   logic          last_rsp = 1'b0;

   always #5 clk_i = ~clk_i;

   fractal_sync_rf_requester #(
      .LEVEL_WIDTH (LW),
      .ID_WIDTH    (IW),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_level_i  (req_level_i),
      .req_id_i     (req_id_i),
      .rf_level_o   (rf_level_o),
      .rf_id_o      (rf_id_o),
      .rf_check_o   (rf_check_o),
      .rf_present_i (rf_present_i),
      .rf_sig_err_i (rf_sig_err_i),
      .rf_bypass_i  (rf_bypass_i),
      .rf_ignore_i  (rf_ignore_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_level_o  (rsp_level_o),
      .rsp_id_o     (rsp_id_o),
      .rsp_kind_o   (rsp_kind_o),
      .err_cnt_o    (err_cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected response kind from the RF result flags, by priority.
   function automatic logic [1:0] model_kind(input logic [3:0] p);
      if (p[3]) return 2'd3;
      if (p[2]) return 2'd2;
      if (p[1] || p[0]) return 2'd1;
      return 2'd0;
   endfunction

   // One clock cycle: check outputs at the falling edge against the model,
   // answer any RF check, then drive inputs for the next rising edge.
   task automatic cyc(input logic v, input logic [LW-1:0] lvl, input logic [IW-1:0] id,
                      input logic [3:0] plan, input logic rdy);
      req_t r;
      rsp_t e;
      @(negedge clk_i);
      cyc_n++;
      last_check = rf_check_o;
      last_rsp   = rsp_valid_o;
      chk("ready", 32'(req_ready_o), 32'(req_q.size() < DEPTH));
      chk("err_cnt", 32'(err_cnt_o), 32'(err_model));
      chk("check_vs_rsp", 32'(rf_check_o & rsp_valid_o), 32'(0));
      if (prev_check) chk("rsp_latency", 32'(rsp_valid_o), 32'(1));
      if (rsp_valid_o) begin
         chk("rsp_pending", 32'(rsp_q.size() > 0), 32'(1));
         if (rsp_q.size() > 0) begin
            chk("rsp_kind", 32'(rsp_kind_o), 32'(rsp_q[0].kind));
            chk("rsp_level", 32'(rsp_level_o), 32'(rsp_q[0].lvl));
            chk("rsp_id", 32'(rsp_id_o), 32'(rsp_q[0].id));
            if (rdy) begin
               e = rsp_q.pop_front();
               hs_log.push_back(e.kind);
               if (e.kind == 2'd3 && err_model != 16'hFFFF) err_model = err_model + 16'd1;
            end
         end
      end
      if (rf_check_o) begin
         chk_cyc.push_back(cyc_n);
         chk("check_pending", 32'(req_q.size() > 0), 32'(1));
         if (req_q.size() > 0) begin
            r = req_q.pop_front();
            chk("rf_level", 32'(rf_level_o), 32'(r.lvl));
            chk("rf_id", 32'(rf_id_o), 32'(r.id));
            {rf_sig_err_i, rf_ignore_i, rf_bypass_i, rf_present_i} = r.plan;
            e.lvl = r.lvl; e.id = r.id; e.kind = model_kind(r.plan);
            rsp_q.push_back(e);
         end
      end else begin
         chk("rf_level_idle", 32'(rf_level_o), 32'(0));
         chk("rf_id_idle", 32'(rf_id_o), 32'(0));
         {rf_sig_err_i, rf_ignore_i, rf_bypass_i, rf_present_i} = 4'($urandom);
      end
      prev_check  = rf_check_o;
      req_valid_i = v;
      req_level_i = lvl;
      req_id_i    = id;
      rsp_ready_i = rdy;
      if (v && req_ready_o) begin
         r.lvl = lvl; r.id = id; r.plan = plan;
         req_q.push_back(r);
      end
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 3'd0, 4'd0, rdy);
   endtask

   // Bounded wait for rsp_valid_o while withholding ready.
   task automatic wait_rsp();
      int k = 0;
      do begin
         cyc(1'b0, 2'd0, 3'd0, 4'd0, 1'b0);
         k++;
      end while (!last_rsp && k < 10);
      chk("wait_rsp", 32'(last_rsp), 32'(1));
   endtask

   initial begin
      int n;
      rst_ni = 1'b0;
      req_valid_i = 1'b0; req_level_i = 2'd0; req_id_i = 3'd0; rsp_ready_i = 1'b0;
      {rf_sig_err_i, rf_ignore_i, rf_bypass_i, rf_present_i} = 4'd0;
      repeat (3) @(negedge clk_i);
      chk("rst_ready", 32'(req_ready_o), 32'(1));
      chk("rst_check", 32'(rf_check_o), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'(0));
      chk("rst_kind", 32'(rsp_kind_o), 32'(0));
      chk("rst_level", 32'(rsp_level_o), 32'(0));
      chk("rst_id", 32'(rsp_id_o), 32'(0));
      chk("rst_err", 32'(err_cnt_o), 32'(0));
      rst_ni = 1'b1;

      // Single request: check one cycle after the push edge, response one later.
      cyc(1'b1, 2'd1, 3'd0, 4'b0000, 1'b1);
      cyc(1'b0, 2'd0, 3'd0, 4'd0, 1'b1);
      chk("single_no_early_check", 32'(last_check), 32'(0));
      cyc(1'b0, 2'd0, 3'd0, 4'd0, 1'b1);
      chk("single_check", 32'(last_check), 32'(1));
      cyc(1'b0, 2'd0, 3'd0, 4'd0, 1'b1);
      chk("single_rsp_valid", 32'(last_rsp), 32'(1));
      chk("single_kind", 32'(rsp_kind_o), 32'(0));
      chk("single_level", 32'(rsp_level_o), 32'(1));
      chk("single_id", 32'(rsp_id_o), 32'(0));
      cyc(1'b0, 2'd0, 3'd0, 4'd0, 1'b1);
      chk("single_one_check", 32'(last_check), 32'(0));

      // Pair completion: WAIT then DONE, in order.
      hs_log.delete();
      cyc(1'b1, 2'd0, 3'd1, 4'b0000, 1'b1);
      cyc(1'b1, 2'd0, 3'd1, 4'b0001, 1'b1);
      idle(8, 1'b1);
      chk("pair_count", 32'(hs_log.size()), 32'(2));
      if (hs_log.size() == 2) begin
         chk("pair_first", 32'(hs_log[0]), 32'(0));
         chk("pair_second", 32'(hs_log[1]), 32'(1));
      end

      // Error response and saturation of the error counter.
      hs_log.delete();
      cyc(1'b1, 2'd2, 3'd3, 4'b1001, 1'b1);
      idle(6, 1'b1);
      chk("err_kind", 32'(hs_log.size() > 0 ? hs_log[0] : 2'd0), 32'(3));
      chk("err_one", 32'(err_cnt_o), 32'(1));
      force dut.err_cnt_q = 16'hFFFE;
      err_model = 16'hFFFE;
      #1 release dut.err_cnt_q;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 2'd3, 3'd7, 4'b1000, 1'b1);
         idle(4, 1'b1);
      end
      chk("err_saturated", 32'(err_cnt_o), 32'h0000FFFF);

      // Backpressure: hold the response, fill the buffer, then drain.
      hs_log.delete();
      chk_cyc.delete();
      cyc(1'b1, 2'd1, 3'd1, 4'b0001, 1'b0);
      wait_rsp();
      cyc(1'b1, 2'd2, 3'd2, 4'b0000, 1'b0);
      cyc(1'b1, 2'd3, 3'd3, 4'b0100, 1'b0);
      cyc(1'b1, 2'd0, 3'd4, 4'b0001, 1'b0);
      chk("bp_full", 32'(req_ready_o), 32'(0));
      idle(3, 1'b0);
      chk("bp_hold_valid", 32'(rsp_valid_o), 32'(1));
      chk("bp_hold_kind", 32'(rsp_kind_o), 32'(1));
      chk("bp_hold_level", 32'(rsp_level_o), 32'(1));
      chk("bp_hold_id", 32'(rsp_id_o), 32'(1));
      idle(12, 1'b1);
      chk("bp_count", 32'(hs_log.size()), 32'(3));
      chk("bp_checks", 32'(chk_cyc.size()), 32'(3));
      if (hs_log.size() == 3 && chk_cyc.size() == 3) begin
         chk("bp_order_a", 32'(hs_log[0]), 32'(1));
         chk("bp_order_b", 32'(hs_log[1]), 32'(0));
         chk("bp_order_c", 32'(hs_log[2]), 32'(2));
         chk("bp_spacing", 32'(chk_cyc[2] - chk_cyc[1]), 32'(2));
      end

      // Priority: ignore beats bypass, bypass alone completes.
      hs_log.delete();
      cyc(1'b1, 2'd1, 3'd2, 4'b0110, 1'b1);
      idle(4, 1'b1);
      cyc(1'b1, 2'd2, 3'd5, 4'b0010, 1'b1);
      idle(4, 1'b1);
      chk("prio_count", 32'(hs_log.size()), 32'(2));
      if (hs_log.size() == 2) begin
         chk("prio_drop", 32'(hs_log[0]), 32'(2));
         chk("prio_done", 32'(hs_log[1]), 32'(1));
      end

      // Reset while a response is pending and one request is buffered.
      cyc(1'b1, 2'd1, 3'd1, 4'b0000, 1'b0);
      wait_rsp();
      cyc(1'b1, 2'd2, 3'd2, 4'b0001, 1'b0);
      cyc(1'b0, 2'd0, 3'd0, 4'd0, 1'b0);
      rst_ni = 1'b0;
      req_q.delete(); rsp_q.delete();
      err_model = 16'd0; prev_check = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'(0));
      chk("midrst_ready", 32'(req_ready_o), 32'(1));
      cyc(1'b0, 2'd0, 3'd0, 4'd0, 1'b1);
      rst_ni = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 2'd0, 3'd0, 4'd0, 1'b1);
         n += int'(last_check);
      end
      chk("midrst_no_check", 32'(n), 32'(0));

      // Randomized traffic against the model, then a bounded drain.
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom), 2'($urandom), 3'($urandom), 4'($urandom),
             ($urandom_range(0, 3) != 0));
      end
      n = 0;
      while ((req_q.size() + rsp_q.size()) > 0 && n < 50) begin
         cyc(1'b0, 2'd0, 3'd0, 4'd0, 1'b1);
         n++;
      end
      chk("drain_empty", 32'(req_q.size() + rsp_q.size()), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
